pipe_trace_capture: RTL and testbench

PIPE_TRACE_CAPTURE -- requirements
Module: pipe_trace_capture

---
 rtl/pipe_trace_pkg.sv | 19 +
 rtl/trace_ram.sv | 23 ++
 rtl/pipe_trace_capture.sv | 177 +++++++++++++++++
 tb/tb_pipe_trace_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared types and sizing helpers for the pipeline trace capture block.
// Stamp width is fixed; stamp storage itself depends on TRACE_TIMESTAMP_EN.
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  localparam int STAMP_W = 16;

  function automatic int entry_w(input int n_stages, input int data_w);
    return n_stages * (data_w + 1) + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port, one registered read port.
// The array has no reset; stale contents are gated off by the controller.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_q
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_q <= r_mem[i_raddr];
  end

endmodule

// File: rtl/pipe_trace_capture.sv
// Circular pipeline trace with overflow trigger and post-trigger window.
// Define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp with each entry.
module pipe_trace_capture
  import pipe_trace_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int N_STAGES  = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [N_STAGES*DATA_W-1:0]             stage_data,
  input  logic [N_STAGES-1:0]                    stage_valid,
  input  logic                                   exc_ovf,
  input  logic                                   arm,
  input  logic                                   rd_req,
  output logic                                   rd_valid,
  output logic [entry_w(N_STAGES, DATA_W)-1:0]   rd_data,
  output logic                                   rd_last,
  output logic [STAMP_W-1:0]                     rd_stamp,
  output logic [2:0]                             state_o,
  output logic                                   triggered
);

  localparam int ENTRY_W = entry_w(N_STAGES, DATA_W);
  localparam int AW      = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int RAM_W   = ENTRY_W + STAMP_W;
`else
  localparam int RAM_W   = ENTRY_W;
`endif
  localparam logic [AW-1:0] PT   = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  state_t         r_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_count;
  logic [AW-1:0]  r_post_cnt;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_rd_left;
  logic           r_trig;
  logic           r_rd_valid;
  logic           r_rd_last;
  logic           r_zero;

  logic           w_cap;
  logic           w_wr;
  logic           w_rd_first;
  logic           w_rd_next;
  logic [AW-1:0]  w_oldest;
  logic [AW-1:0]  w_raddr;
  logic [RAM_W-1:0] w_wdata;
  logic [RAM_W-1:0] w_q;
  logic           w_show;

  assign w_cap      = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr       = w_cap && en && !arm;
  assign w_oldest   = r_wr_ptr - r_count[AW-1:0];
  assign w_rd_first = (r_state == S_DONE) && rd_req && (r_count != '0);
  assign w_rd_next  = (r_state == S_READOUT) && rd_req
                      && (r_rd_left != '0);
  assign w_raddr    = (r_state == S_DONE) ? w_oldest : r_rd_ptr;

`ifdef TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0] r_cyc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cyc <= '0;
    else      r_cyc <= r_cyc + 1'b1;
  end

  assign w_wdata = {r_cyc, exc_ovf, stage_valid, stage_data};
`else
  assign w_wdata = {exc_ovf, stage_valid, stage_data};
`endif

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RAM_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_first || w_rd_next),
    .i_raddr (w_raddr),
    .o_q     (w_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_post_cnt <= '0;
      r_rd_ptr   <= '0;
      r_rd_left  <= '0;
      r_trig     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != FULL) r_count <= r_count + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_ARMED;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_trig   <= 1'b0;
          end
        end
        S_ARMED, S_POST: begin
          if (arm) begin
            r_state  <= S_ARMED;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_trig   <= 1'b0;
          end else if (en) begin
            if (r_state == S_ARMED) begin
              if (exc_ovf) begin
                r_trig     <= 1'b1;
                r_post_cnt <= PT;
                r_state    <= (POST_TRIG == 0) ? S_DONE : S_POST;
              end
            end else begin
              r_post_cnt <= r_post_cnt - 1'b1;
              if (r_post_cnt == AW'(1)) r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (rd_req) begin
            r_state    <= S_READOUT;
            r_zero     <= (r_count == '0);
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_count <= (AW+1)'(1));
            r_rd_ptr   <= w_oldest + 1'b1;
            r_rd_left  <= (r_count == '0) ? '0 : r_count - 1'b1;
          end
        end
        S_READOUT: begin
          if (r_rd_valid && r_rd_last) begin
            r_state <= S_IDLE;
          end else if (w_rd_next) begin
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_rd_left == (AW+1)'(1));
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_rd_left  <= r_rd_left - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM output is unreset; only expose it alongside a real entry.
  assign w_show    = r_rd_valid && !r_zero;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = w_show ? w_q[ENTRY_W-1:0] : '0;
  assign state_o   = r_state;
  assign triggered = r_trig;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_stamp  = w_show ? w_q[RAM_W-1 -: STAMP_W] : '0;
`else
  assign rd_stamp  = '0;
`endif

endmodule

// File: tb/tb_pipe_trace_capture.sv
// Scoreboard bench for pipe_trace_capture (default and POST_TRIG=0).
// Readout requests push expected entries; monitors pop on rd_valid.
module tb_pipe_trace_capture;
  import pipe_trace_pkg::*;

  localparam int DW = 16;
  localparam int NS = 5;
  localparam int EW = entry_w(NS, DW);

  typedef struct packed {
    logic [EW-1:0] d;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, exc = 1'b0;
  logic arm = 1'b0, rd_req = 1'b0;
  logic arm1 = 1'b0, rd_req1 = 1'b0;
  logic [NS*DW-1:0] sd = '0;
  logic [NS-1:0]    sv = '0;

  logic          rd_valid0, rd_last0, trig0;
  logic [EW-1:0] rd_data0;
  logic [15:0]   rd_stamp0;
  logic [2:0]    state0;
  logic          rd_valid1, rd_last1, trig1;
  logic [EW-1:0] rd_data1;
  logic [15:0]   rd_stamp1;
  logic [2:0]    state1;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [EW-1:0] m0[$];
  logic [EW-1:0] m1[$];
  bit cap0 = 0, cap1 = 0;

  pipe_trace_capture u_dut0 (
    .clk(clk), .rst(rst), .en(en),
    .stage_data(sd), .stage_valid(sv),
    .exc_ovf(exc), .arm(arm), .rd_req(rd_req),
    .rd_valid(rd_valid0), .rd_data(rd_data0),
    .rd_last(rd_last0), .rd_stamp(rd_stamp0),
    .state_o(state0), .triggered(trig0)
  );

  pipe_trace_capture #(.POST_TRIG(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
    .stage_data(sd), .stage_valid(sv),
    .exc_ovf(exc), .arm(arm1), .rd_req(rd_req1),
    .rd_valid(rd_valid1), .rd_data(rd_data1),
    .rd_last(rd_last1), .rd_stamp(rd_stamp1),
    .state_o(state1), .triggered(trig1)
  );

  always #5 clk = ~clk;

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [EW-1:0] act,
                      input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [NS*DW-1:0] mk(input int k);
    logic [NS*DW-1:0] r;
    for (int s = 0; s < NS; s++) r[s*DW +: DW] = DW'(k * 16 + s);
    return r;
  endfunction

  task automatic cyc(input bit e, input bit x, input int k);
    @(posedge clk); #1;
    en = e; exc = x; sd = mk(k); sv = 5'(k);
    if (e && cap0) begin
      m0.push_back({x, sv, sd});
      if (m0.size() > 16) void'(m0.pop_front());
    end
    if (e && cap1) begin
      m1.push_back({x, sv, sd});
      if (m1.size() > 16) void'(m1.pop_front());
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    en = 0; exc = 0;
  endtask

  task automatic pulse_arm();
    @(posedge clk); #1;
    arm = 1; en = 0; exc = 0;
    m0.delete(); cap0 = 1;
    @(posedge clk); #1;
    arm = 0;
  endtask

  task automatic readout0(input int n);
    cap0 = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_req = 1;
      q0.push_back({m0[i], (i == m0.size() - 1)});
    end
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic full_readout0(input string nm);
    readout0(m0.size());
    @(posedge clk); #1;
    rd_req = 1;
    @(posedge clk); #1;
    rd_req = 1;
    @(posedge clk); #1;
    rd_req = 0;
    chki({nm, "_idle_after"}, int'(state0), int'(S_IDLE));
  endtask

  // Output monitors: everything presented must be expected, in order.
  logic [15:0] prev0;
  bit          first0 = 1;
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected: got data %h expected none",
                 rd_data0);
      end else begin
        e = q0.pop_front();
        chkd("dut0_data", rd_data0, e.d);
        chki("dut0_last", int'(rd_last0), int'(e.last));
`ifdef TRACE_TIMESTAMP_EN
        if (!first0)
          chki("dut0_stamp_step", int'(rd_stamp0),
               int'(16'(prev0 + 16'd1)));
        prev0  = rd_stamp0;
        first0 = e.last;
`else
        chki("dut0_stamp_zero", int'(rd_stamp0), 0);
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected: got data %h expected none",
                 rd_data1);
      end else begin
        e = q1.pop_front();
        chkd("dut1_data", rd_data1, e.d);
        chki("dut1_last", int'(rd_last1), int'(e.last));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chki("rst_state", int'(state0), int'(S_IDLE));
    chki("rst_valid", int'(rd_valid0), 0);
    chki("rst_last", int'(rd_last0), 0);
    chki("rst_trig", int'(trig0), 0);
    chkd("rst_data", rd_data0, '0);
    chki("rst_stamp", int'(rd_stamp0), 0);
    chki("rst_state1", int'(state1), int'(S_IDLE));
    rst = 1;

    // 4 plain, trigger on 5th, 8 post-trigger entries
    pulse_arm();
    chki("t1_armed", int'(state0), int'(S_ARMED));
    for (int k = 1; k <= 4; k++) cyc(1, 0, k);
    cyc(1, 1, 5);
    for (int k = 6; k <= 13; k++) cyc(1, 0, k);
    chki("t1_post", int'(state0), int'(S_POST));
    idle();
    chki("t1_done", int'(state0), int'(S_DONE));
    chki("t1_trig", int'(trig0), 1);
    @(posedge clk); #1 arm = 1;
    @(posedge clk); #1 arm = 0;
    chki("t1_arm_in_done", int'(state0), int'(S_DONE));
    chki("t1_count", m0.size(), 13);
    full_readout0("t1");

    // 40 plain entries (wraps), stray en=0 overflow, trigger, 8 post
    pulse_arm();
    for (int k = 1; k <= 40; k++) begin
      if (k == 20) cyc(0, 1, 99);
      cyc(1, 0, k);
    end
    chki("t2_armed", int'(state0), int'(S_ARMED));
    cyc(1, 1, 41);
    for (int k = 42; k <= 49; k++) cyc(1, (k == 45), k);
    chki("t2_post", int'(state0), int'(S_POST));
    idle();
    chki("t2_done", int'(state0), int'(S_DONE));
    chki("t2_count", m0.size(), 16);
    full_readout0("t2");

    // arm while in POST restarts the capture from empty
    pulse_arm();
    for (int k = 1; k <= 3; k++) cyc(1, 0, k);
    cyc(1, 1, 4);
    cyc(1, 0, 5);
    cyc(1, 0, 6);
    pulse_arm();
    chki("t3_rearm_state", int'(state0), int'(S_ARMED));
    chki("t3_rearm_trig", int'(trig0), 0);
    cyc(1, 0, 7);
    cyc(1, 0, 8);
    cyc(1, 1, 9);
    for (int k = 10; k <= 17; k++) cyc(1, 0, k);
    idle();
    chki("t3_done", int'(state0), int'(S_DONE));
    chki("t3_count", m0.size(), 11);
    full_readout0("t3");

    // reset in the middle of a readout
    pulse_arm();
    for (int k = 1; k <= 5; k++) cyc(1, 0, k);
    cyc(1, 1, 6);
    for (int k = 7; k <= 14; k++) cyc(1, 0, k);
    idle();
    chki("t4_done", int'(state0), int'(S_DONE));
    readout0(3);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chki("t4_rst_valid", int'(rd_valid0), 0);
    chki("t4_rst_state", int'(state0), int'(S_IDLE));
    @(posedge clk); #1 rst = 1;
    rd_req = 1;
    repeat (2) @(posedge clk);
    #1 rd_req = 0;
    @(posedge clk); #1;
    chki("t4_after_state", int'(state0), int'(S_IDLE));

    // POST_TRIG=0: trigger on first entry goes straight to DONE
    @(posedge clk); #1;
    arm1 = 1; m1.delete(); cap1 = 1;
    @(posedge clk); #1 arm1 = 0;
    cyc(1, 1, 100);
    idle();
    chki("t5_done", int'(state1), int'(S_DONE));
    chki("t5_trig", int'(trig1), 1);
    cap1 = 0;
    chki("t5_count", m1.size(), 1);
    @(posedge clk); #1;
    rd_req1 = 1;
    q1.push_back({m1[0], 1'b1});
    @(posedge clk); #1 rd_req1 = 1;
    @(posedge clk); #1 rd_req1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chki("t5_idle_after", int'(state1), int'(S_IDLE));

    repeat (3) @(posedge clk);
    chki("q0_drained", q0.size(), 0);
    chki("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
